// File: rtl/demux_1to2.sv
`default_nettype none
// ============================================================================
// Module   : demux_1to2
// Purpose  : Registered 1-to-2 stream demultiplexer. Each accepted input word
//            is routed to channel A (in_sel=0) or channel B (in_sel=1). Each
//            channel owns a single-entry output register with its own
//            valid/ready handshake, so a stalled channel never blocks traffic
//            routed to the other one. Per-channel wrapping transfer counters
//            are provided for bring-up and debug.
//
// Ports    : clk      - clock, all state updates on the rising edge
//            rst      - synchronous active-high reset
//            in_data  - input word (WIDTH)
//            in_sel   - route select, 0 = channel A, 1 = channel B
//            in_valid - input word / in_sel valid
//            in_ready - input accepted this cycle (combinational)
//            a_data   - channel A registered word (WIDTH)
//            a_valid  - channel A holds a word
//            a_ready  - channel A consumer accepts
//            b_data   - channel B registered word (WIDTH)
//            b_valid  - channel B holds a word
//            b_ready  - channel B consumer accepts
//            a_count  - completed channel A handshakes (CNT_W, wraps)
//            b_count  - completed channel B handshakes (CNT_W, wraps)
//
// Revision : 1.0 - initial release
// ============================================================================
module demux_1to2 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    // Channel registers
    logic             r_a_valid;
    logic             r_b_valid;
    logic [WIDTH-1:0] r_a_data;
    logic [WIDTH-1:0] r_b_data;
    logic [CNT_W-1:0] r_a_count;
    logic [CNT_W-1:0] r_b_count;

    // Handshake decode
    logic w_a_xfer;
    logic w_b_xfer;
    logic w_in_ready;
    logic w_accept;
    logic w_a_load;
    logic w_b_load;

    assign w_a_xfer = r_a_valid && a_ready;
    assign w_b_xfer = r_b_valid && b_ready;

    // Readiness depends only on the selected channel: a full, stalled
    // channel back-pressures only the words routed to it. Including the
    // consumer's ready lets a full channel drain and reload in one cycle.
    assign w_in_ready = in_sel ? (!r_b_valid || b_ready)
                               : (!r_a_valid || a_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_a_load   = w_accept && !in_sel;
    assign w_b_load   = w_accept &&  in_sel;

    // Channel A register. A load takes precedence over a drain so that a
    // same-cycle drain and reload keeps valid high with the new word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_valid <= 1'b0;
            r_a_data  <= '0;
            r_a_count <= '0;
        end else begin
            if (w_a_load) begin
                r_a_valid <= 1'b1;
                r_a_data  <= in_data;
            end else if (w_a_xfer) begin
                r_a_valid <= 1'b0;
            end
            if (w_a_xfer) begin
                r_a_count <= r_a_count + c_CNT_ONE;
            end
        end
    end

    // Channel B register, independent of channel A.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_b_valid <= 1'b0;
            r_b_data  <= '0;
            r_b_count <= '0;
        end else begin
            if (w_b_load) begin
                r_b_valid <= 1'b1;
                r_b_data  <= in_data;
            end else if (w_b_xfer) begin
                r_b_valid <= 1'b0;
            end
            if (w_b_xfer) begin
                r_b_count <= r_b_count + c_CNT_ONE;
            end
        end
    end

    assign in_ready = w_in_ready;
    assign a_data   = r_a_data;
    assign a_valid  = r_a_valid;
    assign b_data   = r_b_data;
    assign b_valid  = r_b_valid;
    assign a_count  = r_a_count;
    assign b_count  = r_b_count;

endmodule
`default_nettype wire

// File: tb/tb_demux_1to2.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_1to2
// Purpose  : Self-checking bench for demux_1to2. Directed scenarios followed
//            by randomized traffic, all compared every cycle against a
//            transaction-level reference model (per-channel occupancy, last
//            word, unbounded transfer totals and expected-word queues).
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_1to2;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [CNT_W-1:0] a_count;
    logic [CNT_W-1:0] b_count;

    always #5 clk = ~clk;

    demux_1to2 #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: channel occupancy, last word seen on each output,
    // total transfers (the DUT counter is this modulo 2^CNT_W) and the words
    // each consumer is still owed, in order.
    bit               m_full [2];
    logic [WIDTH-1:0] m_last [2];
    int               m_xfers[2];
    logic [WIDTH-1:0] q_a[$];
    logic [WIDTH-1:0] q_b[$];

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_full[c]  = 1'b0;
            m_last[c]  = '0;
            m_xfers[c] = 0;
        end
        q_a.delete();
        q_b.delete();
    endfunction

    function automatic bit exp_in_ready();
        return in_sel ? (!m_full[1] || b_ready) : (!m_full[0] || a_ready);
    endfunction

    // One clock cycle: check outputs mid-cycle, then advance the model
    // across the rising edge using the inputs that were applied.
    task automatic step();
        bit acc, a_out, b_out;
        @(negedge clk);
        check_value("a_valid",  {31'd0, a_valid}, {31'd0, m_full[0]});
        check_value("b_valid",  {31'd0, b_valid}, {31'd0, m_full[1]});
        check_value("a_data",   32'(a_data), 32'(m_last[0]));
        check_value("b_data",   32'(b_data), 32'(m_last[1]));
        check_value("a_count",  32'(a_count), 32'(m_xfers[0] % (1 << CNT_W)));
        check_value("b_count",  32'(b_count), 32'(m_xfers[1] % (1 << CNT_W)));
        check_value("in_ready", {31'd0, in_ready}, {31'd0, exp_in_ready()});
        acc   = in_valid && exp_in_ready() && !rst;
        a_out = m_full[0] && a_ready;
        b_out = m_full[1] && b_ready;
        if (!rst && a_out && q_a.size() > 0) check_value("a_emit", 32'(a_data), 32'(q_a.pop_front()));
        if (!rst && b_out && q_b.size() > 0) check_value("b_emit", 32'(b_data), 32'(q_b.pop_front()));
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            if (a_out) begin
                m_xfers[0]++;
                m_full[0] = 1'b0;
            end
            if (b_out) begin
                m_xfers[1]++;
                m_full[1] = 1'b0;
            end
            if (acc && !in_sel) begin
                m_full[0] = 1'b1;
                m_last[0] = in_data;
                q_a.push_back(in_data);
            end
            if (acc && in_sel) begin
                m_full[1] = 1'b1;
                m_last[1] = in_data;
                q_b.push_back(in_data);
            end
        end
    endtask

    task automatic drive(input bit r, input bit v, input bit s,
                         input logic [WIDTH-1:0] d, input bit ar, input bit br);
        rst      = r;
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        a_ready  = ar;
        b_ready  = br;
        step();
    endtask

    initial begin
        // Bring-up: first reset edge establishes a known state.
        rst = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h1;
        a_ready = 1'b0; b_ready = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset held a second cycle with a valid input present.
        drive(1, 1, 0, 4'h1, 0, 0);
        rst = 1'b0; in_valid = 1'b0; in_sel = 1'b0;
        #1 check_value("rst_in_ready_a", {31'd0, in_ready}, 32'd1);
        in_sel = 1'b1;
        #1 check_value("rst_in_ready_b", {31'd0, in_ready}, 32'd1);
        check_value("rst_a_valid", {31'd0, a_valid}, 32'd0);
        check_value("rst_b_count", 32'(b_count), 32'd0);

        // Alternating routing with both consumers ready.
        drive(0, 1, 0, 4'h0, 1, 1);
        drive(0, 1, 0, 4'h1, 1, 1);
        drive(0, 1, 1, 4'h0, 1, 1);
        drive(0, 1, 1, 4'h1, 1, 1);
        drive(0, 0, 0, 4'h0, 1, 1);
        drive(0, 0, 0, 4'h0, 1, 1);
        check_value("alt_a_count", 32'(a_count), 32'd2);
        check_value("alt_b_count", 32'(b_count), 32'd2);

        // Stall isolation.
        drive(1, 0, 0, 4'h0, 0, 0);
        drive(0, 1, 0, 4'h3, 0, 0);
        rst = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h5;
        #1 check_value("stall_in_ready", {31'd0, in_ready}, 32'd0);
        check_value("stall_a_data", 32'(a_data), 32'h3);
        step();
        drive(0, 1, 1, 4'h7, 0, 1);
        check_value("iso_b_data", 32'(b_data), 32'h7);
        check_value("iso_b_valid", {31'd0, b_valid}, 32'd1);
        drive(0, 1, 0, 4'h5, 1, 1);
        check_value("drain_a_data", 32'(a_data), 32'h5);
        check_value("drain_a_count", 32'(a_count), 32'd1);

        // Same-cycle drain and load on A.
        drive(0, 1, 0, 4'h9, 1, 1);
        check_value("dl_a_valid", {31'd0, a_valid}, 32'd1);
        check_value("dl_a_data", 32'(a_data), 32'h9);
        check_value("dl_a_count", 32'(a_count), 32'd2);
        drive(0, 0, 0, 4'h0, 1, 1);

        // Counter wrap on B: five transfers.
        drive(1, 0, 0, 4'h0, 1, 1);
        for (int i = 0; i < 5; i++) drive(0, 1, 1, 4'(i + 2), 1, 1);
        drive(0, 0, 0, 4'h0, 1, 1);
        check_value("wrap_b_count", 32'(b_count), 32'd1);
        check_value("wrap_a_count", 32'(a_count), 32'd0);

        // Reset mid-stream with a stalled word in A.
        drive(0, 1, 0, 4'hC, 0, 1);
        drive(1, 1, 0, 4'hD, 0, 1);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 4'h0, 1, 1);
        check_value("mid_a_valid", {31'd0, a_valid}, 32'd0);
        check_value("mid_a_count", 32'(a_count), 32'd0);
        check_value("mid_a_data", 32'(a_data), 32'd0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 49) == 0), $urandom_range(0, 3) != 0,
                  1'($urandom), 4'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 2) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demux_1to2.md
# demux_1to2

Registered 1-to-2 stream demultiplexer: the routing counterpart of `mux_2to1`, splitting one input stream onto two output channels instead of merging two inputs onto one. Each accepted input word goes to channel A (`sel=0`) or channel B (`sel=1`). Each channel has its own single-entry output register with valid/ready handshake, so a stalled channel does not block transfers routed to the other one. Per-channel transfer counters support bring-up and debug.

## Interface
- `WIDTH`, default 1: data width of input and both outputs.
- `CNT_W`, default 8: width of each per-channel transfer counter.

- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input WIDTH: input word.
- `in_sel` input 1: route select for `in_data`; 0 = channel A, 1 = channel B.
- `in_valid` input 1: input word and `in_sel` are valid.
- `in_ready` output 1: demux accepts the input this cycle.
- `a_data` output WIDTH: channel A word (registered).
- `a_valid` output 1: channel A holds a word.
- `a_ready` input 1: channel A consumer accepts.
- `b_data` output WIDTH: channel B word (registered).
- `b_valid` output 1: channel B holds a word.
- `b_ready` input 1: channel B consumer accepts.
- `a_count` output CNT_W: completed channel A handshakes.
- `b_count` output CNT_W: completed channel B handshakes.

## Operation
- Input transfer (accept) occurs when `in_valid && in_ready`. `in_sel` and `in_data` are sampled only on accept.
- `in_ready` is combinational:
  - `in_sel=0`: `in_ready = !a_valid || a_ready`.
  - `in_sel=1`: `in_ready = !b_valid || b_ready`.
- Output transfer on channel X occurs when `X_valid && X_ready`.
- Per-channel register update, channel X, at each clock edge:
  - Accept routed to X: `X_data <= in_data`, `X_valid <= 1`. This applies whether or not X is draining in the same cycle.
  - No accept to X, but an output transfer on X: `X_valid <= 0`. `X_data` holds its old value.
  - Otherwise: hold.
- The unselected channel is never modified by an accept.
- While `X_valid=1 && X_ready=0`, `X_data` and `X_valid` must stay stable.
- Counters:
  - `X_count` increments by 1 on each output transfer on X.
  - It wraps from 2^CNT_W−1 to 0 with no saturation and no flag.
- The two channels are fully independent. A stall on A never gates B traffic, and the reverse holds too.

## Timing
- Reset values (synchronous `rst=1` at an edge):
  - `a_valid=0`, `b_valid=0`.
  - `a_data=0`, `b_data=0`.
  - `a_count=0`, `b_count=0`.
  - `in_ready` then evaluates to 1 for either `in_sel`.
- `rst` takes priority over all other activity in that cycle:
  - Any word held in a channel register is dropped.
  - An accept in the reset cycle is discarded.
- Latency: a word accepted at edge N appears on `X_data` with `X_valid=1` immediately after edge N. Its earliest output transfer is at edge N+1.
- Throughput: one word per cycle per channel when the consumer holds `ready=1`, including back-to-back same-channel traffic (drain and reload in the same cycle).
- Channel full and not ready: `in_ready=0` only for inputs routed there. Input routed to the other channel is still accepted that cycle.
- `in_valid=0`: no state change except output drains and counter increments.

## Test plan
- Reset: hold `rst=1` for 2 cycles with `in_valid=1`, data 0x1 → after release `a_valid=b_valid=0`, counts 0, `in_ready=1`.
- Alternating routing (WIDTH=1), `a_ready=b_ready=1`:
  - Drive (data,sel) = (0,0),(1,0),(0,1),(1,1), one per cycle, mirroring the mux bench vectors.
  - Required: A emits 0 then 1, B emits 0 then 1, each 1 cycle after accept.
  - Final `a_count=2`, `b_count=2`.
- Stall isolation:
  - Hold `a_ready=0`, send one word to A, then a second word to A → `in_ready=0` and `a_data` holds the first word.
  - Then send a word to B → accepted immediately and appears on B the next cycle.
  - Raise `a_ready` → the first A word drains and the pending A word is accepted in the same cycle.
- Same-cycle drain and load: with `a_valid=1`, `a_ready=1`, accept a new A word → `a_valid` stays 1, `a_data` updates to the new word, and `a_count` increments by exactly 1.
- Counter wrap (CNT_W=2): complete 5 transfers on B → `b_count` sequence 1,2,3,0,1 and `a_count` stays 0.
- Reset mid-stream: with `a_valid=1` and `a_ready=0`, assert `rst` for 1 cycle → `a_valid=0`, data and counts 0, and no word is emitted afterward.
